// File: rtl/elevator_collective.sv
// Collective (SCAN) elevator controller for any floor count. Car and hall calls
// are latched into lamp registers. The car serves calls in its direction of travel
// and reverses only when no requests remain ahead. When the emergency input rises
// in any state, the car stops at the next floor with the door held open.
module elevator_collective #(
  parameter int FLOORS      = 6,
  parameter int DOOR_CYCLES = 16,
  parameter int FW          = $clog2(FLOORS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLOORS-1:0]         f,
  input  logic [2*(FLOORS-1)-1:0]   du,
  input  logic [FLOORS-1:0]         sensors,
  input  logic                      emg,
  output logic [1:0]                ac,
  output logic [FW-1:0]             disp,
  output logic                      open,
  output logic [FLOORS-1:0]         car_lamp,
  output logic [2*(FLOORS-1)-1:0]   hall_lamp
);

  localparam int            TW        = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR, S_EMG} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
  logic [FW-1:0]     cur_q, cur_d;
  logic              valid_q, valid_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              left_q, left_d;         // origin sensor has been left since departure
  logic              emg_pend_q, emg_pend_d; // emergency seen while moving

  // Bits of a one-hot position vector's floors strictly above / below it.
  function automatic logic [FLOORS-1:0] mask_above(input logic [FLOORS-1:0] oh);
    logic [FLOORS-1:0] r;
    logic              seen;
    seen = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      r[i] = seen;
      seen = seen | oh[i];
    end
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] mask_below(input logic [FLOORS-1:0] oh);
    logic [FLOORS-1:0] r;
    logic              seen;
    seen = 1'b0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      r[i] = seen;
      seen = seen | oh[i];
    end
    return r;
  endfunction

  // Hall buttons unpacked onto per-floor vectors; U at the top and D at the bottom don't exist.
  logic [FLOORS-1:0] up_set, dn_set, req_all, cur_oh;
  assign up_set  = {1'b0, du[FLOORS-2:0]};
  assign dn_set  = {du[2*FLOORS-3:FLOORS-1], 1'b0};
  assign req_all = car_q | up_q | dn_q;

  // One-hot view of the registered floor.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < FLOORS; i++) cur_oh[i] = (cur_q == FW'(i));
  end

  logic sens_onehot, sens_zero;
  assign sens_onehot = $onehot(sensors);
  assign sens_zero   = (sensors == '0);

  // Request look-ahead from the parked floor (IDLE) and from the sensor being passed (moving).
  logic above_cur, below_cur, above_k, below_k;
  assign above_cur = |(req_all & mask_above(cur_oh));
  assign below_cur = |(req_all & mask_below(cur_oh));
  assign above_k   = |(req_all & mask_above(sensors));
  assign below_k   = |(req_all & mask_below(sensors));

  // What IDLE may serve at the parked floor: hall calls against dir only once nothing lies ahead.
  logic car_here, served_up, served_dn;
  assign car_here  = |(car_q & cur_oh);
  assign served_up = (|(up_q & cur_oh)) && (dir_q != DIR_DOWN || !below_cur);
  assign served_dn = (|(dn_q & cur_oh)) && (dir_q != DIR_UP || !above_cur);

  // Stop checks ignore the origin floor until the car has left it.
  logic stop_up, stop_dn;
  assign stop_up = left_q && sens_onehot &&
                   ((|(car_q & sensors)) || (|(up_q & sensors)) || !above_k ||
                    sensors[FLOORS-1] || emg || emg_pend_q);
  assign stop_dn = left_q && sens_onehot &&
                   ((|(car_q & sensors)) || (|(dn_q & sensors)) || !below_k ||
                    sensors[0] || emg || emg_pend_q);

  // With the door open, calls at this floor for the current direction extend the door rather than latch.
  logic              in_door, reopen;
  logic [FLOORS-1:0] abs_car, abs_up, abs_dn;
  assign in_door = (state_q == S_DOOR);
  assign abs_car = in_door ? cur_oh : '0;
  assign abs_up  = (in_door && dir_q != DIR_DOWN) ? cur_oh : '0;
  assign abs_dn  = (in_door && dir_q != DIR_UP) ? cur_oh : '0;
  assign reopen  = (|(f & abs_car)) || (|(up_set & abs_up)) || (|(dn_set & abs_dn));

  logic [FLOORS-1:0] clr_car, clr_up, clr_dn;

  // Next-state, request bookkeeping and motor command.
  always_comb begin
    // NOTE: every _d and output gets its default first, so no path leaves one unassigned (no latch).
    state_d    = state_q;
    dir_d      = dir_q;
    cur_d      = cur_q;
    valid_d    = valid_q;
    timer_d    = timer_q;
    left_d     = left_q;
    emg_pend_d = emg_pend_q;
    clr_car    = '0;
    clr_up     = '0;
    clr_dn     = '0;
    ac         = 2'b00;

    if (sens_onehot) begin
      valid_d = 1'b1;
      for (int i = 0; i < FLOORS; i++) if (sensors[i]) cur_d = FW'(i);
    end

    unique case (state_q)
      S_IDLE: begin
        if (valid_q && sens_onehot) begin
          if (emg) begin
            state_d = S_EMG;
          end else if (car_here || served_up || served_dn) begin
            state_d = S_DOOR;
            timer_d = DOOR_LOAD;
            clr_car = cur_oh;
            if (served_up) clr_up = cur_oh;
            if (served_dn) clr_dn = cur_oh;
            if (served_up && !served_dn) dir_d = DIR_UP;
            if (served_dn && !served_up) dir_d = DIR_DOWN;
          end else if (above_cur && (!below_cur || dir_q != DIR_DOWN)) begin
            state_d    = S_MOVE_UP;
            dir_d      = DIR_UP;
            left_d     = 1'b0;
            emg_pend_d = 1'b0;
          end else if (below_cur) begin
            state_d    = S_MOVE_DN;
            dir_d      = DIR_DOWN;
            left_d     = 1'b0;
            emg_pend_d = 1'b0;
          end else begin
            dir_d = DIR_NONE;
          end
        end
      end
      S_MOVE_UP: begin
        ac         = 2'b01;
        emg_pend_d = emg_pend_q | emg;
        if (sens_zero) left_d = 1'b1;
        if (stop_up) begin
          ac      = 2'b00;
          clr_car = sensors;
          clr_up  = sensors;
          if (!above_k) begin
            clr_dn = sensors;
            dir_d  = below_k ? DIR_DOWN : DIR_NONE;
          end
          state_d = emg ? S_EMG : S_DOOR;
          timer_d = DOOR_LOAD;
        end
      end
      S_MOVE_DN: begin
        ac         = 2'b10;
        emg_pend_d = emg_pend_q | emg;
        if (sens_zero) left_d = 1'b1;
        if (stop_dn) begin
          ac      = 2'b00;
          clr_car = sensors;
          clr_dn  = sensors;
          if (!below_k) begin
            clr_up = sensors;
            dir_d  = above_k ? DIR_UP : DIR_NONE;
          end
          state_d = emg ? S_EMG : S_DOOR;
          timer_d = DOOR_LOAD;
        end
      end
      S_DOOR: begin
        if (emg) begin
          state_d = S_EMG;
        end else if (reopen) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q <= TW'(1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_EMG: begin
        if (!emg) begin
          state_d = S_DOOR;
          timer_d = DOOR_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear first, then set: a same-cycle press survives unless the open door absorbs it.
    car_d = (car_q & ~clr_car) | (f & ~abs_car);
    up_d  = (up_q & ~clr_up) | (up_set & ~abs_up);
    dn_d  = (dn_q & ~clr_dn) | (dn_set & ~abs_dn);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_NONE;
      car_q      <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      cur_q      <= '0;
      valid_q    <= 1'b0;
      timer_q    <= '0;
      left_q     <= 1'b0;
      emg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      car_q      <= car_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      cur_q      <= cur_d;
      valid_q    <= valid_d;
      timer_q    <= timer_d;
      left_q     <= left_d;
      emg_pend_q <= emg_pend_d;
    end
  end

  assign open      = (state_q == S_DOOR) || (state_q == S_EMG);
  assign disp      = valid_q ? cur_q + FW'(1) : '0;
  assign car_lamp  = car_q;
  assign hall_lamp = {dn_q[FLOORS-1:1], up_q[FLOORS-2:0]};

endmodule

// File: tb/tb_elevator_collective.sv
// Directed bench for elevator_collective: a vector table for latching, packing and
// position decode, followed by hand-stepped ride sequences through the floors.
module tb_elevator_collective;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  f, sensors;
  logic [9:0]  du;
  logic        emg;
  logic [1:0]  ac;
  logic [2:0]  disp;
  logic        open;
  logic [5:0]  car_lamp;
  logic [9:0]  hall_lamp;

  logic [17:0] du10, hall10;
  logic [1:0]  ac10;
  logic [3:0]  disp10;
  logic        open10;
  logic [9:0]  car10;

  logic [1:0]  du2, hall2, ac2, disp2, car2;
  logic        open2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  elevator_collective #(.FLOORS(6), .DOOR_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .f(f), .du(du), .sensors(sensors), .emg(emg),
    .ac(ac), .disp(disp), .open(open), .car_lamp(car_lamp), .hall_lamp(hall_lamp)
  );

  elevator_collective #(.FLOORS(10), .DOOR_CYCLES(16)) dut10 (
    .clk(clk), .rst(rst), .f(10'b0), .du(du10), .sensors(10'b0), .emg(1'b0),
    .ac(ac10), .disp(disp10), .open(open10), .car_lamp(car10), .hall_lamp(hall10)
  );

  elevator_collective #(.FLOORS(2), .DOOR_CYCLES(16)) dut2 (
    .clk(clk), .rst(rst), .f(2'b0), .du(du2), .sensors(2'b0), .emg(1'b0),
    .ac(ac2), .disp(disp2), .open(open2), .car_lamp(car2), .hall_lamp(hall2)
  );

  typedef struct {
    logic [5:0] sens;
    logic [5:0] f;
    logic [9:0] du;
    logic [2:0] exp_disp;
    logic [5:0] exp_car;
    logic [9:0] exp_hall;
    logic [1:0] exp_ac;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] fl(input int n);
    logic [5:0] r;
    r = '0;
    if (n > 0) r[n-1] = 1'b1;
    return r;
  endfunction

  // Leave the current floor, arrive at floor n, check the motor command there, take the edge.
  task automatic pass_floor(input int n, input logic [1:0] exp_ac);
    sensors = '0;
    tick();
    sensors = fl(n);
    #1;
    check($sformatf("ac_at_floor%0d", n), {30'b0, ac}, {30'b0, exp_ac});
    tick();
  endtask

  // Count open cycles starting in an open cycle, bounded.
  task automatic wait_door_close(input string name, input int exp_len);
    int n;
    n = 0;
    while (open && n < 200) begin
      n++;
      tick();
    end
    check(name, n, exp_len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int bad;
    vecs[0] = '{sens: 6'b000000, f: 6'b000000, du: 10'h000, exp_disp: 3'd0, exp_car: 6'b000000, exp_hall: 10'h000, exp_ac: 2'b00};
    vecs[1] = '{sens: 6'b000011, f: 6'b000100, du: 10'h000, exp_disp: 3'd0, exp_car: 6'b000100, exp_hall: 10'h000, exp_ac: 2'b00};
    vecs[2] = '{sens: 6'b000000, f: 6'b000000, du: 10'h001, exp_disp: 3'd0, exp_car: 6'b000100, exp_hall: 10'h001, exp_ac: 2'b00};
    vecs[3] = '{sens: 6'b000000, f: 6'b000000, du: 10'h200, exp_disp: 3'd0, exp_car: 6'b000100, exp_hall: 10'h201, exp_ac: 2'b00};
    vecs[4] = '{sens: 6'b110000, f: 6'b000100, du: 10'h001, exp_disp: 3'd0, exp_car: 6'b000100, exp_hall: 10'h201, exp_ac: 2'b00};
    vecs[5] = '{sens: 6'b000100, f: 6'b000000, du: 10'h000, exp_disp: 3'd3, exp_car: 6'b000100, exp_hall: 10'h201, exp_ac: 2'b00};

    rst = 1'b1; f = '0; du = '0; sensors = '0; emg = 1'b0; du10 = '0; du2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ac", {30'b0, ac}, 0);
    check("rst_disp", {29'b0, disp}, 0);
    check("rst_open", {31'b0, open}, 0);
    check("rst_car_lamp", {26'b0, car_lamp}, 0);
    check("rst_hall_lamp", {22'b0, hall_lamp}, 0);

    // Latching, packing and position decode with no valid position, so the car never moves.
    for (int i = 0; i < 6; i++) begin
      sensors = vecs[i].sens; f = vecs[i].f; du = vecs[i].du;
      tick();
      f = '0; du = '0;
      check($sformatf("vec%0d_disp", i), {29'b0, disp}, {29'b0, vecs[i].exp_disp});
      check($sformatf("vec%0d_car", i), {26'b0, car_lamp}, {26'b0, vecs[i].exp_car});
      check($sformatf("vec%0d_hall", i), {22'b0, hall_lamp}, {22'b0, vecs[i].exp_hall});
      check($sformatf("vec%0d_ac_open", i), {29'b0, ac, open}, {29'b0, vecs[i].exp_ac, 1'b0});
    end

    // Hall packing on the other sizes: D10 is du[17], D2 is du[1] on two floors.
    du10 = 18'h20000; du2 = 2'b10;
    tick();
    du10 = '0; du2 = '0;
    check("f10_d10_lamp", {14'b0, hall10}, 32'h20000);
    check("f2_d2_lamp", {30'b0, hall2}, 2);
    check("f10_idle_ac", {30'b0, ac10}, 0);

    rst = 1'b1; sensors = fl(1);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("a_disp1", {29'b0, disp}, 1);

    // Collective order: F6 then U3 from floor 1 -> stop at 3, then 6.
    f = fl(6); tick(); f = '0;
    check("a_f6_lamp", {26'b0, car_lamp}, 6'b100000);
    du = 10'h004; tick(); du = '0;
    check("a_depart_ac", {30'b0, ac}, 1);
    check("a_u3_lamp", {22'b0, hall_lamp}, 10'h004);
    pass_floor(2, 2'b01);
    pass_floor(3, 2'b00);
    check("a_open3", {31'b0, open}, 1);
    check("a_disp3", {29'b0, disp}, 3);
    check("a_u3_cleared", {22'b0, hall_lamp}, 0);
    check("a_f6_still_on", {26'b0, car_lamp}, 6'b100000);
    wait_door_close("a_door3_len", 16);
    tick();
    check("a_resume_ac", {30'b0, ac}, 1);
    pass_floor(4, 2'b01);
    pass_floor(5, 2'b01);
    pass_floor(6, 2'b00);
    check("a_disp6", {29'b0, disp}, 6);
    check("a_f6_cleared", {26'b0, car_lamp}, 0);
    wait_door_close("a_door6_len", 16);

    // Reversal: D4, U2, F1 from floor 6 -> 4, 1, then up to 2.
    f = fl(1); du = 10'h082; tick(); f = '0; du = '0;
    check("b_lamps", {16'b0, car_lamp, hall_lamp}, {16'b0, 6'b000001, 10'h082});
    tick();
    check("b_depart_ac", {30'b0, ac}, 2);
    pass_floor(5, 2'b10);
    pass_floor(4, 2'b00);
    check("b_disp4", {29'b0, disp}, 4);
    check("b_d4_cleared", {22'b0, hall_lamp}, 10'h002);
    wait_door_close("b_door4_len", 16);
    tick();
    pass_floor(3, 2'b10);
    pass_floor(2, 2'b10);
    pass_floor(1, 2'b00);
    check("b_f1_cleared", {16'b0, car_lamp, hall_lamp}, {16'b0, 6'b0, 10'h002});
    wait_door_close("b_door1_len", 16);
    tick();
    check("b_up_ac", {30'b0, ac}, 1);
    pass_floor(2, 2'b00);
    check("b_u2_cleared", {22'b0, hall_lamp}, 0);
    wait_door_close("b_door2_len", 16);

    // Emergency mid-move: stop at the next sensor regardless of requests.
    f = fl(6); tick(); f = '0;
    tick();
    check("c_depart_ac", {30'b0, ac}, 1);
    sensors = '0; emg = 1'b1;
    tick();
    sensors = fl(3);
    #1;
    check("c_emg_stop_ac", {30'b0, ac}, 0);
    tick();
    check("c_emg_open", {31'b0, open}, 1);
    check("c_emg_disp", {29'b0, disp}, 3);
    f = fl(5); tick(); f = '0;
    check("c_latch_in_emg", {26'b0, car_lamp}, 6'b110000);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!open || ac != 2'b00) bad++;
    end
    check("c_emg_hold", bad, 0);
    emg = 1'b0;
    tick();
    wait_door_close("c_release_len", 16);
    tick();
    check("c_resume_ac", {30'b0, ac}, 1);
    pass_floor(4, 2'b01);
    pass_floor(5, 2'b00);
    check("c_f5_cleared", {26'b0, car_lamp}, 6'b100000);
    wait_door_close("c_door5_len", 16);
    tick();

    // Reopen and de-dup at the top floor with dir NONE.
    pass_floor(6, 2'b00);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) f = fl(6); else du = 10'h200;
      tick();
      f = '0; du = '0;
      tick();
    end
    check("d_lamps_absorbed", {16'b0, car_lamp, hall_lamp}, 0);
    check("d_still_open", {31'b0, open}, 1);
    wait_door_close("d_reopen_len", 15);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (open || ac != 2'b00) bad++;
    end
    check("d_quiet_after_close", bad, 0);

    // Reset mid-move, then recovery once a sensor is seen.
    f = fl(1); tick(); f = '0;
    tick();
    check("e_depart_ac", {30'b0, ac}, 2);
    sensors = '0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("e_rst_ac", {30'b0, ac}, 0);
    check("e_rst_lamps", {16'b0, car_lamp, hall_lamp}, 0);
    check("e_rst_disp", {29'b0, disp}, 0);
    f = fl(3); tick(); f = '0;
    tick(); tick();
    check("e_no_pos_ac", {30'b0, ac}, 0);
    check("e_f3_lamp", {26'b0, car_lamp}, 6'b000100);
    sensors = fl(5);
    tick();
    check("e_disp5", {29'b0, disp}, 5);
    check("e_first_seen_ac", {30'b0, ac}, 0);
    tick();
    check("e_move_ac", {30'b0, ac}, 2);
    pass_floor(4, 2'b10);
    pass_floor(3, 2'b00);
    check("e_open3", {31'b0, open}, 1);
    check("e_f3_cleared", {26'b0, car_lamp}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
